// File: rtl/operand_fetch_r_if.sv
// Purpose : Bundles the instruction-in, writeback and ALU-out handshakes of
//           the operand_fetch_r stage into one interface.
// Ports   :
//   iIR_VALID / oIR_READY / iIR           upstream instruction handshake
//   iWB_EN / iWB_RD / iWB_DATA            register-file write port
//   oEX_VALID / iEX_READY                 downstream ALU handshake
//   oIR, oRS1, oRS2, oRD                  held instruction and its fields
//   oALU_IN1 / oALU_IN2                   held operands
//   oILLEGAL                              dropped non-R-type pulse
// Modports: slave = the fetch stage itself, master = its environment.
interface operand_fetch_r_if #(
    parameter int XLEN = 32
);
    logic            iIR_VALID;
    logic            oIR_READY;
    logic [31:0]     iIR;
    logic            iWB_EN;
    logic [4:0]      iWB_RD;
    logic [XLEN-1:0] iWB_DATA;
    logic            oEX_VALID;
    logic            iEX_READY;
    logic [31:0]     oIR;
    logic [4:0]      oRS1;
    logic [4:0]      oRS2;
    logic [4:0]      oRD;
    logic [XLEN-1:0] oALU_IN1;
    logic [XLEN-1:0] oALU_IN2;
    logic            oILLEGAL;

    modport slave (
        input  iIR_VALID, iIR, iWB_EN, iWB_RD, iWB_DATA, iEX_READY,
        output oIR_READY, oEX_VALID, oIR, oRS1, oRS2, oRD,
               oALU_IN1, oALU_IN2, oILLEGAL
    );

    modport master (
        output iIR_VALID, iIR, iWB_EN, iWB_RD, iWB_DATA, iEX_READY,
        input  oIR_READY, oEX_VALID, oIR, oRS1, oRS2, oRD,
               oALU_IN1, oALU_IN2, oILLEGAL
    );
endinterface

// File: rtl/operand_fetch_r.sv
// Purpose : Decode / operand-fetch stage feeding the R-type ALU. Holds the
//           integer register file, reads rs1/rs2 with same-cycle writeback
//           forwarding and presents a single registered output slot.
// Ports   :
//   iCLK    clock, rising edge
//   iRST_N  asynchronous active-low reset
//   bus     operand_fetch_r_if.slave (instruction in, writeback, ALU out)
module operand_fetch_r #(
    parameter int         XLEN  = 32,
    parameter int         NREG  = 32,
    parameter logic [6:0] OPC_R = 7'b0110011
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    operand_fetch_r_if.slave   bus
);

    // Register file and output slot state
    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    logic            ex_valid_q, ex_valid_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] alu1_q, alu1_d;
    logic [XLEN-1:0] alu2_q, alu2_d;
    logic            illegal_q, illegal_d;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            ir_ready;
    logic            accept;
    logic            consume;
    logic            is_r;
    logic            wb_hit;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    // x0 reads as zero; a write landing this edge is forwarded so the
    // captured operand never lags the register file by one cycle.
    function automatic logic [XLEN-1:0] read_op(
        input logic [4:0]      rs,
        input logic            wb_en,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data,
        input logic [XLEN-1:0] rf_val
    );
        if (rs == 5'd0)
            return '0;
        else if (wb_en && (wb_rd == rs))
            return wb_data;
        else
            return rf_val;
    endfunction

    assign rs1      = bus.iIR[19:15];
    assign rs2      = bus.iIR[24:20];
    assign ir_ready = !ex_valid_q || bus.iEX_READY;
    assign accept   = bus.iIR_VALID && ir_ready;
    assign consume  = ex_valid_q && bus.iEX_READY;
    assign is_r     = (bus.iIR[6:0] == OPC_R);
    assign wb_hit   = bus.iWB_EN && (bus.iWB_RD != 5'd0);

    assign op1 = read_op(rs1, bus.iWB_EN, bus.iWB_RD, bus.iWB_DATA, rf_q[rs1]);
    assign op2 = read_op(rs2, bus.iWB_EN, bus.iWB_RD, bus.iWB_DATA, rf_q[rs2]);

    always_comb begin
        rf_d       = rf_q;
        ex_valid_d = ex_valid_q;
        ir_d       = ir_q;
        alu1_d     = alu1_q;
        alu2_d     = alu2_q;
        illegal_d  = 1'b0;

        if (wb_hit)
            rf_d[bus.iWB_RD] = bus.iWB_DATA;

        if (consume)
            ex_valid_d = 1'b0;

        if (accept) begin
            if (is_r) begin
                ex_valid_d = 1'b1;
                ir_d       = bus.iIR;
                alu1_d     = op1;
                alu2_d     = op2;
            end else begin
                illegal_d  = 1'b1;
            end
        end else if (ex_valid_q && !bus.iEX_READY) begin
            // Stalled slot: keep held operands coherent with writeback so
            // the ALU sees the newest value when it finally consumes.
            if (wb_hit && (bus.iWB_RD == ir_q[19:15]))
                alu1_d = bus.iWB_DATA;
            if (wb_hit && (bus.iWB_RD == ir_q[24:20]))
                alu2_d = bus.iWB_DATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
            ex_valid_q <= 1'b0;
            ir_q       <= '0;
            alu1_q     <= '0;
            alu2_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            ex_valid_q <= ex_valid_d;
            ir_q       <= ir_d;
            alu1_q     <= alu1_d;
            alu2_q     <= alu2_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.oIR_READY = ir_ready;
    assign bus.oEX_VALID = ex_valid_q;
    assign bus.oIR       = ir_q;
    assign bus.oRS1      = ir_q[19:15];
    assign bus.oRS2      = ir_q[24:20];
    assign bus.oRD       = ir_q[11:7];
    assign bus.oALU_IN1  = alu1_q;
    assign bus.oALU_IN2  = alu2_q;
    assign bus.oILLEGAL  = illegal_q;

endmodule

// File: tb/tb_operand_fetch_r.sv
module tb_operand_fetch_r;

    logic iCLK;
    logic iRST_N;

    operand_fetch_r_if #(.XLEN(32)) bus ();

    operand_fetch_r #(.XLEN(32), .NREG(32), .OPC_R(7'b0110011)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus.slave)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        v;
        logic [31:0] ir;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        er;
        logic        x_rdy;
        logic        x_vld;
        logic        x_ill;
        logic        chk;
        logic [31:0] x_a1;
        logic [31:0] x_a2;
        logic [4:0]  x_rd;
    } vec_t;

    vec_t vt [18];

    function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [4:0] d);
        return {f7, s2, s1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic vec_t mk(
        input logic v, input logic [31:0] ir, input logic we, input logic [4:0] rd,
        input logic [31:0] wd, input logic er, input logic x_rdy, input logic x_vld,
        input logic x_ill, input logic chk, input logic [31:0] x_a1,
        input logic [31:0] x_a2, input logic [4:0] x_rd);
        vec_t r;
        r.v = v; r.ir = ir; r.we = we; r.rd = rd; r.wd = wd; r.er = er;
        r.x_rdy = x_rdy; r.x_vld = x_vld; r.x_ill = x_ill; r.chk = chk;
        r.x_a1 = x_a1; r.x_a2 = x_a2; r.x_rd = x_rd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd, input logic er);
        bus.iIR_VALID = v;
        bus.iIR       = ir;
        bus.iWB_EN    = we;
        bus.iWB_RD    = rd;
        bus.iWB_DATA  = wd;
        bus.iEX_READY = er;
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    localparam logic [31:0] ADD_7_5_6  = 32'h006283B3;
    localparam logic [31:0] LW_OP      = 32'h0002A303;
    localparam logic [31:0] NEG16      = 32'hFFFF_FFF0;
    localparam logic [31:0] PAT        = 32'h1234_5678;

    initial begin
        logic [31:0] add17;
        add17 = r_enc(7'h00, 5'd6, 5'd5, 5'd17);

        //           v  ir                          we rd  wd            er rdy vld ill chk a1     a2     rd
        vt[0]  = mk(0, 32'h0,                      1, 5,  32'h7,        1, 1,  0,  0,  0,  0,     0,     0);
        vt[1]  = mk(0, 32'h0,                      1, 6,  32'h3,        1, 1,  0,  0,  0,  0,     0,     0);
        vt[2]  = mk(1, ADD_7_5_6,                  0, 0,  32'h0,        1, 1,  1,  0,  1,  32'h7, 32'h3, 7);
        vt[3]  = mk(0, 32'h0,                      0, 0,  32'h0,        1, 1,  0,  0,  0,  0,     0,     0);
        vt[4]  = mk(1, r_enc(7'h20, 5, 5, 8),      1, 5,  NEG16,        1, 1,  1,  0,  1,  NEG16, NEG16, 8);
        vt[5]  = mk(1, r_enc(7'h00, 0, 5, 9),      0, 0,  32'h0,        1, 1,  1,  0,  1,  NEG16, 0,     9);
        vt[6]  = mk(0, 32'h0,                      1, 0,  32'hDEADBEEF, 1, 1,  0,  0,  0,  0,     0,     0);
        vt[7]  = mk(1, r_enc(7'h00, 0, 0, 10),     1, 0,  32'hCAFEBABE, 1, 1,  1,  0,  1,  0,     0,     10);
        vt[8]  = mk(0, 32'h0,                      0, 0,  32'h0,        1, 1,  0,  0,  0,  0,     0,     0);
        vt[9]  = mk(1, r_enc(7'h00, 6, 5, 11),     0, 0,  32'h0,        0, 1,  1,  0,  1,  NEG16, 32'h3, 11);
        vt[10] = mk(1, r_enc(7'h00, 6, 6, 12),     1, 6,  PAT,          0, 0,  1,  0,  1,  NEG16, PAT,   11);
        vt[11] = mk(1, r_enc(7'h00, 6, 6, 12),     0, 0,  32'h0,        1, 1,  1,  0,  1,  PAT,   PAT,   12);
        vt[12] = mk(1, r_enc(7'h00, 6, 5, 13),     0, 0,  32'h0,        1, 1,  1,  0,  1,  NEG16, PAT,   13);
        vt[13] = mk(1, r_enc(7'h00, 5, 6, 14),     0, 0,  32'h0,        1, 1,  1,  0,  1,  PAT,   NEG16, 14);
        vt[14] = mk(1, r_enc(7'h00, 0, 7, 15),     0, 0,  32'h0,        1, 1,  1,  0,  1,  0,     0,     15);
        vt[15] = mk(1, r_enc(7'h00, 6, 6, 1),      0, 0,  32'h0,        1, 1,  1,  0,  1,  PAT,   PAT,   1);
        vt[16] = mk(1, LW_OP,                      0, 0,  32'h0,        1, 1,  0,  1,  0,  0,     0,     0);
        vt[17] = mk(0, 32'h0,                      0, 0,  32'h0,        1, 1,  0,  0,  0,  0,     0,     0);

        drive(0, 32'h0, 0, 0, 32'h0, 0);
        iRST_N = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst_ex_valid", {31'b0, bus.oEX_VALID}, 32'h0);
        chk("rst_illegal",  {31'b0, bus.oILLEGAL},  32'h0);
        chk("rst_ir",       bus.oIR,                32'h0);
        chk("rst_alu1",     bus.oALU_IN1,           32'h0);
        chk("rst_alu2",     bus.oALU_IN2,           32'h0);
        chk("rst_ready",    {31'b0, bus.oIR_READY}, 32'h1);
        iRST_N = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].v, vt[i].ir, vt[i].we, vt[i].rd, vt[i].wd, vt[i].er);
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, bus.oIR_READY}, {31'b0, vt[i].x_rdy});
            step();
            chk($sformatf("v%0d_ex_valid", i), {31'b0, bus.oEX_VALID}, {31'b0, vt[i].x_vld});
            chk($sformatf("v%0d_illegal", i),  {31'b0, bus.oILLEGAL},  {31'b0, vt[i].x_ill});
            if (vt[i].chk) begin
                chk($sformatf("v%0d_alu1", i), bus.oALU_IN1, vt[i].x_a1);
                chk($sformatf("v%0d_alu2", i), bus.oALU_IN2, vt[i].x_a2);
                chk($sformatf("v%0d_rd", i),   {27'b0, bus.oRD}, {27'b0, vt[i].x_rd});
            end
        end

        // Stalled slot: rs1 refresh, oIR held, then asynchronous reset mid-stall.
        drive(1, add17, 0, 0, 32'h0, 0);
        step();
        chk("stall_load_valid", {31'b0, bus.oEX_VALID}, 32'h1);
        chk("stall_load_alu1",  bus.oALU_IN1, NEG16);
        chk("stall_load_alu2",  bus.oALU_IN2, PAT);
        drive(0, 32'h0, 1, 5, 32'h55, 0);
        step();
        chk("stall_refresh_alu1", bus.oALU_IN1, 32'h55);
        chk("stall_refresh_alu2", bus.oALU_IN2, PAT);
        chk("stall_ir_held",      bus.oIR,      add17);
        chk("stall_rs1",          {27'b0, bus.oRS1}, 32'd5);
        chk("stall_ready_low",    {31'b0, bus.oIR_READY}, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("arst_ex_valid", {31'b0, bus.oEX_VALID}, 32'h0);
        chk("arst_alu1",     bus.oALU_IN1, 32'h0);
        chk("arst_ir",       bus.oIR,      32'h0);
        iRST_N = 1'b1;
        drive(1, r_enc(7'h00, 5'd5, 5'd5, 5'd18), 0, 0, 32'h0, 1);
        step();
        chk("post_rst_valid", {31'b0, bus.oEX_VALID}, 32'h1);
        chk("post_rst_x5_a1", bus.oALU_IN1, 32'h0);
        chk("post_rst_x5_a2", bus.oALU_IN2, 32'h0);
        drive(0, 32'h0, 0, 0, 32'h0, 1);
        step();
        chk("post_rst_drain", {31'b0, bus.oEX_VALID}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/operand_fetch_r.md
Name: operand_fetch_r

Overview:
Decode/operand-fetch stage directly upstream of the R-type ALU stage. Holds the 32x32 integer register file and accepts fetched instructions over a valid/ready handshake. Reads rs1/rs2 with same-cycle writeback forwarding and presents a registered instruction plus both operands to the ALU over a second valid/ready handshake. Writeback arrives on a dedicated write port from the downstream writeback stage.

Parameters:
XLEN, 32, data width of registers and operands
NREG, 32, number of architectural registers; x0 is hardwired to zero
OPC_R, 7'b0110011, opcode accepted as R-type

Ports:
iCLK  in  1  clock, all state updates on rising edge
iRST_N  in  1  asynchronous active-low reset
iIR_VALID  in  1  upstream instruction valid
oIR_READY  out  1  stage can accept an instruction this cycle
iIR  in  32  upstream instruction word
iWB_EN  in  1  register write enable from writeback
iWB_RD  in  5  writeback destination register
iWB_DATA  in  XLEN  writeback data
oEX_VALID  out  1  output slot holds an instruction for the ALU
iEX_READY  in  1  ALU consumes the output slot this cycle
oIR  out  32  held instruction word
oRS1  out  5  held iIR[19:15]
oRS2  out  5  held iIR[24:20]
oRD  out  5  held iIR[11:7]
oALU_IN1  out  XLEN  operand for rs1
oALU_IN2  out  XLEN  operand for rs2
oILLEGAL  out  1  one-cycle pulse: a non-R-type instruction was accepted and dropped

Behaviour:
- Reset (iRST_N low, asynchronous): all registers = 0, oEX_VALID = 0, oIR/oALU_IN1/oALU_IN2 = 0, oILLEGAL = 0. Any in-flight instruction is discarded. Reset takes effect mid-handshake without waiting for a clock edge.
- oIR_READY = !oEX_VALID || iEX_READY (combinational). It is a single output register, with no skid buffer.
- Accept = iIR_VALID && oIR_READY.
  - Accept of an R-type instruction (iIR[6:0] == OPC_R): the next edge loads oIR and the operands, and sets oEX_VALID = 1. Accept-to-oEX_VALID latency is 1 cycle.
  - Accept of a non-R-type instruction: the output slot is not loaded, and oEX_VALID falls if it was consumed. oILLEGAL = 1 for exactly the following cycle.
- Consume = oEX_VALID && iEX_READY. If consume happens with no accept, oEX_VALID -> 0 next edge. Simultaneous consume and accept gives back-to-back throughput of 1 per cycle.
- Operand read: value = 0 if rs == 0. Otherwise, if iWB_EN && iWB_RD == rs, value = iWB_DATA (forward). Otherwise value = regfile[rs]. rs1 and rs2 are evaluated independently; rs1 == rs2 is legal.
- Write: on the edge with iWB_EN && iWB_RD != 0, regfile[iWB_RD] <= iWB_DATA. A write to x0 is ignored. A write occurs regardless of handshake state.
- Stall refresh: while oEX_VALID && !iEX_READY, a write with iWB_RD != 0 equal to the held oRS1 (or oRS2) updates oALU_IN1 (or oALU_IN2) on the same edge. Both are updated if both match. oIR is unchanged.
- With oEX_VALID = 0, the output fields hold their last values; the ALU must ignore them.
- All arithmetic is width-exact; no sign handling in this stage.

Test Plan:
- Reset then write x5=0x0000_0007 and x6=0x0000_0003, then present add x7,x5,x6 (0x006283B3) with iEX_READY=1 -> next cycle oEX_VALID=1, oALU_IN1=7, oALU_IN2=3, oRD=7; oEX_VALID=0 the cycle after.
- Same-cycle forward: present sub x8,x5,x5 while iWB_EN=1, iWB_RD=5, iWB_DATA=0xFFFF_FFF0 -> both operands = 0xFFFF_FFF0, and x5 reads 0xFFFF_FFF0 afterwards.
- x0 rules: write iWB_RD=0 with 0xDEAD_BEEF, then read rs1=0 -> oALU_IN1 = 0, including when forwarding conditions are otherwise met.
- Stall: hold iEX_READY=0 with an instruction reading x6 in the slot, and write x6=0x1234_5678 -> oALU_IN2 becomes 0x1234_5678 while oIR_READY=0; a new iIR_VALID is not accepted until iEX_READY=1.
- Throughput and illegal: stream 4 R-type instructions with iEX_READY=1 -> 4 consecutive oEX_VALID cycles. Then present lw (opcode 0x03) -> oILLEGAL pulses for 1 cycle and oEX_VALID=0.
- Reset mid-stall: drop iRST_N asynchronously between edges while oEX_VALID=1 -> oEX_VALID=0 immediately, and x5 reads 0 after release.
